// File: rtl/pig_spawner.sv
// Spawn controller for the moving target sprite: requests a random row from the
// upstream stage, places the sprite, walks it left once per frame, then cools down.
module pig_spawner #(
  parameter int Y_BASE          = 64,
  parameter int Y_STEP          = 32,
  parameter int Y_MAX           = 400,
  parameter int X_START         = 600,
  parameter int X_MIN           = 0,
  parameter int SPEED           = 2,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int RAND_BITS       = 5
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 enable,
  input  logic                 hit,
  input  logic [RAND_BITS-1:0] rand_y,
  output logic                 rise,
  output logic signed [10:0]   topLeftX,
  output logic signed [10:0]   topLeftY,
  output logic                 visible,
  output logic [7:0]           spawn_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_LATCH,
    S_ACTIVE,
    S_COOLDOWN
  } state_e;

  localparam logic signed [11:0] SpeedS   = 12'(SPEED);
  localparam logic signed [11:0] XMinS    = 12'(X_MIN);
  localparam logic        [15:0] YMax16   = 16'(Y_MAX);
  localparam logic        [15:0] CoolLoad = 16'(COOLDOWN_FRAMES);

  state_e state_q, state_d;

  logic                rise_q, rise_d;
  logic signed [10:0]  topLeftX_q, topLeftX_d;
  logic signed [10:0]  topLeftY_q, topLeftY_d;
  logic                visible_q, visible_d;
  logic [7:0]          spawnCount_q, spawnCount_d;
  logic [15:0]         cool_q, cool_d;

  logic [15:0]         yRaw;
  logic signed [11:0]  xMoved;
  logic                xExits;

  // One extra bit on X so a step past the left edge is seen as negative, not wrapped.
  assign yRaw   = 16'(Y_BASE) + 16'(rand_y) * 16'(Y_STEP);
  assign xMoved = $signed({topLeftX_q[10], topLeftX_q}) - SpeedS;
  assign xExits = (xMoved <= XMinS);

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q      <= S_IDLE;
      rise_q       <= 1'b0;
      topLeftX_q   <= 11'(X_START);
      topLeftY_q   <= 11'(Y_BASE);
      visible_q    <= 1'b0;
      spawnCount_q <= 8'd0;
      cool_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      rise_q       <= rise_d;
      topLeftX_q   <= topLeftX_d;
      topLeftY_q   <= topLeftY_d;
      visible_q    <= visible_d;
      spawnCount_q <= spawnCount_d;
      cool_q       <= cool_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (enable) state_d = S_REQ;
      S_REQ:      state_d = S_WAIT;
      S_WAIT:     state_d = S_LATCH;
      S_LATCH:    state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (hit) begin
          state_d = S_COOLDOWN;
        end else if (startOfFrame && xExits) begin
          state_d = S_COOLDOWN;
        end
      end
      S_COOLDOWN: begin
        if (cool_q == 16'd0) begin
          state_d = enable ? S_REQ : S_IDLE;
        end
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // Rise is registered from the next state, so it is high exactly while in REQ.
  always_comb begin
    rise_d       = (state_d == S_REQ);
    topLeftX_d   = topLeftX_q;
    topLeftY_d   = topLeftY_q;
    visible_d    = visible_q;
    spawnCount_d = spawnCount_q;
    cool_d       = cool_q;
    case (state_q)
      S_LATCH: begin
        topLeftY_d   = (yRaw > YMax16) ? 11'(Y_MAX) : yRaw[10:0];
        topLeftX_d   = 11'(X_START);
        visible_d    = 1'b1;
        spawnCount_d = spawnCount_q + 8'd1;
      end
      S_ACTIVE: begin
        if (hit) begin
          visible_d = 1'b0;
          cool_d    = CoolLoad;
        end else if (startOfFrame) begin
          if (xExits) begin
            topLeftX_d = 11'(X_MIN);
            visible_d  = 1'b0;
            cool_d     = CoolLoad;
          end else begin
            topLeftX_d = xMoved[10:0];
          end
        end
      end
      S_COOLDOWN: begin
        if (cool_q != 16'd0 && startOfFrame) begin
          cool_d = cool_q - 16'd1;
        end
      end
      default: ;
    endcase
  end

  assign rise        = rise_q;
  assign topLeftX    = topLeftX_q;
  assign topLeftY    = topLeftY_q;
  assign visible     = visible_q;
  assign spawn_count = spawnCount_q;

endmodule

// File: tb/tb_pig_spawner.sv
// Bench for pig_spawner: a default instance for spawn/clamp/hit/enable/reset checks,
// and a short-travel instance (X_START=10, SPEED=4) for the exit path.
module tb_pig_spawner;

  typedef struct {
    int y;
    int x;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetN, enable, startOfFrame, hit;
  logic [4:0]        rand_y = 5'd0;
  logic              rise, visible;
  logic signed [10:0] topLeftX, topLeftY;
  logic [7:0]        spawn_count;

  logic              resetB, enableB, sofB, hitB;
  logic [4:0]        randB = 5'd0;
  logic              riseB, visibleB;
  logic signed [10:0] xB, yB;
  logic [7:0]        countB;

  int   total = 0;
  int   bad = 0;
  int   riseCount = 0;
  int   riseCountB = 0;
  logic prevRise = 1'b0;
  logic prevVis = 1'b0;
  logic [4:0] nextRand = 5'd0;
  exp_t sb[$];
  exp_t e;

  pig_spawner dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .hit(hit), .rand_y(rand_y), .rise(rise), .topLeftX(topLeftX),
    .topLeftY(topLeftY), .visible(visible), .spawn_count(spawn_count)
  );

  pig_spawner #(.X_START(10), .SPEED(4)) dutB (
    .clk(clk), .resetN(resetB), .startOfFrame(sofB), .enable(enableB),
    .hit(hitB), .rand_y(randB), .rise(riseB), .topLeftX(xB),
    .topLeftY(yB), .visible(visibleB), .spawn_count(countB)
  );

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Upstream random stage: answers a rise one cycle later.
  always @(posedge clk) begin
    if (rise) begin
      check("riseSingle", int'(prevRise), 0);
      riseCount++;
      rand_y <= nextRand;
    end
    prevRise = rise;
    if (riseB) begin
      riseCountB++;
      randB <= 5'd3;
    end
  end

  // Monitor: every new spawn must match the next queued expectation.
  always @(negedge clk) begin
    if (visible === 1'b1 && prevVis === 1'b0) begin
      if (sb.size() == 0) begin
        check("spawnUnexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("spawnY", int'(topLeftY), e.y);
        check("spawnX", int'(topLeftX), e.x);
        check("spawnCount", int'(spawn_count), e.cnt);
      end
    end
    prevVis = visible;
  end

  task automatic frameA();
    @(negedge clk) startOfFrame = 1'b1;
    @(negedge clk) startOfFrame = 1'b0;
  endtask

  task automatic framesA(input int n);
    for (int i = 0; i < n; i++) frameA();
  endtask

  task automatic frameB();
    @(negedge clk) sofB = 1'b1;
    @(negedge clk) sofB = 1'b0;
  endtask

  task automatic waitRiseA(input int maxCycles);
    int k = 0;
    while (rise !== 1'b1 && k < maxCycles) begin
      @(negedge clk);
      k++;
    end
    check("riseSeen", int'(rise), 1);
  endtask

  task automatic waitRiseB(input int maxCycles);
    int k = 0;
    while (riseB !== 1'b1 && k < maxCycles) begin
      @(negedge clk);
      k++;
    end
    check("riseSeenB", int'(riseB), 1);
  endtask

  task automatic applyStimulus();
    // Exit path on the short-travel instance.
    resetB = 1'b0;
    enableB = 1'b1;
    waitRiseB(5);
    for (int k = 0; k < 6 && visibleB !== 1'b1; k++) @(negedge clk);
    check("exitVisible", int'(visibleB), 1);
    check("exitX0", int'(xB), 10);
    check("exitY", int'(yB), 160);
    check("exitCount", int'(countB), 1);
    frameB();
    check("exitX1", int'(xB), 6);
    frameB();
    check("exitX2", int'(xB), 2);
    check("exitVis2", int'(visibleB), 1);
    frameB();
    check("exitX3", int'(xB), 0);
    check("exitVis3", int'(visibleB), 0);
    for (int i = 0; i < 29; i++) frameB();
    check("exitNoRise", riseCountB, 1);
    frameB();
    waitRiseB(5);
    resetB = 1'b1;

    // Basic spawn with row 3.
    nextRand = 5'd3;
    sb.push_back('{160, 600, 1});
    enable = 1'b1;
    waitRiseA(5);
    @(negedge clk);
    check("visN1", int'(visible), 0);
    check("riseN1", int'(rise), 0);
    @(negedge clk);
    check("visN2", int'(visible), 0);
    @(negedge clk);
    check("visN3", int'(visible), 1);
    check("riseCount1", riseCount, 1);

    // Walk to X=100, then hit and frame together.
    framesA(250);
    check("walkX", int'(topLeftX), 100);
    check("walkVis", int'(visible), 1);
    @(negedge clk);
    hit = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    startOfFrame = 1'b0;
    check("simulX", int'(topLeftX), 100);
    check("simulVis", int'(visible), 0);

    // Stray hit during cooldown must not disturb the frame count.
    @(negedge clk) hit = 1'b1;
    @(negedge clk) hit = 1'b0;
    nextRand = 5'd31;
    sb.push_back('{400, 600, 2});
    framesA(29);
    check("coolNoRise", riseCount, 1);
    frameA();
    waitRiseA(5);
    repeat (3) @(negedge clk);

    // Enable dropped while active: finish the run, then stay idle.
    enable = 1'b0;
    framesA(299);
    check("dropX2", int'(topLeftX), 2);
    check("dropVis2", int'(visible), 1);
    frameA();
    check("dropX0", int'(topLeftX), 0);
    check("dropVis0", int'(visible), 0);
    framesA(30);
    repeat (10) @(negedge clk);
    check("dropNoRise", riseCount, 2);
    nextRand = 5'd0;
    sb.push_back('{64, 600, 3});
    enable = 1'b1;
    waitRiseA(5);
    repeat (3) @(negedge clk);
    check("riseCount3", riseCount, 3);

    // Reset while waiting on the upstream stage.
    @(negedge clk) hit = 1'b1;
    @(negedge clk) hit = 1'b0;
    check("hitVis", int'(visible), 0);
    nextRand = 5'd10;
    framesA(30);
    waitRiseA(5);
    @(negedge clk);
    resetN = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    resetN = 1'b0;
    check("rstRise", int'(rise), 0);
    check("rstVis", int'(visible), 0);
    check("rstCount", int'(spawn_count), 0);
    check("rstX", int'(topLeftX), 600);
    check("rstY", int'(topLeftY), 64);
    repeat (5) @(negedge clk);
    check("noLatchVis", int'(visible), 0);
    check("noLatchY", int'(topLeftY), 64);

    // Row 11 overshoots the clamp; count restarts after reset.
    nextRand = 5'd11;
    sb.push_back('{400, 600, 1});
    enable = 1'b1;
    waitRiseA(5);
    repeat (4) @(negedge clk);
  endtask

  task automatic checkOutput();
    check("sbEmpty", sb.size(), 0);
  endtask

  initial begin
    resetN = 1'b1;
    enable = 1'b0;
    startOfFrame = 1'b0;
    hit = 1'b0;
    resetB = 1'b1;
    enableB = 1'b0;
    sofB = 1'b0;
    hitB = 1'b0;
    repeat (2) @(negedge clk);
    check("resetRise", int'(rise), 0);
    check("resetX", int'(topLeftX), 600);
    check("resetY", int'(topLeftY), 64);
    check("resetVis", int'(visible), 0);
    check("resetCount", int'(spawn_count), 0);
    resetN = 1'b0;
    applyStimulus();
    checkOutput();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
